mp_operand_loader: RTL
======================

MP_OPERAND_LOADER -- requirements
Module: mp_operand_loader

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 1027, meaning operand width in bits.
REQ-002 SHALL have parameter WORD, default 32, meaning stream word width.
REQ-003 SHALL have parameter NWORDS, default 33, meaning words per operand or result, ceil((OP_WIDTH+1)/WORD).
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles to wait for add_done.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-007 SHALL have ports s_data (input, WORD), s_valid (input, 1), s_ready (output, 1): the operand word stream, least-significant word first.
REQ-008 SHALL have port s_sub, input, 1 bit: the operation select, sampled with word 0 of A (1 = A-B).
REQ-009 SHALL have ports m_data (output, WORD), m_valid (output, 1), m_ready (input, 1), m_last (output, 1): the result word stream.
REQ-010 SHALL have ports add_a and add_b (output, OP_WIDTH each), add_subtract (output, 1), add_start (output, 1): the drive to the multiprecision adder.
REQ-011 SHALL have ports add_result (input, OP_WIDTH+1) and add_done (input, 1): the adder response.
REQ-012 SHALL have ports busy (output, 1), high outside LOAD_A or while word count is nonzero, and err (output, 1), a one-cycle timeout pulse.

Function
REQ-013 SHALL implement the FSM states LOAD_A, LOAD_B, FIRE, WAIT and DRAIN.
REQ-014 In LOAD_A and LOAD_B, s_ready SHALL be 1; a word is accepted on s_valid&&s_ready; in all other states s_ready SHALL be 0.
REQ-015 Accepted word k SHALL land in operand bits [WORD*k+WORD-1 : WORD*k]; bits at or above OP_WIDTH of word NWORDS-1 are discarded.
REQ-016 On the NWORDS-th accepted word, LOAD_A SHALL transition to LOAD_B and LOAD_B SHALL transition to FIRE; gaps in s_valid stall without loss.
REQ-017 FIRE SHALL last exactly one cycle with add_start=1, then transition to WAIT.
REQ-018 add_a, add_b and add_subtract SHALL be held stable from FIRE until WAIT exits.
REQ-019 In WAIT, add_done=1 SHALL capture add_result into the result register and transition to DRAIN on the next edge.
REQ-020 WAIT SHALL count cycles; if TIMEOUT cycles elapse without add_done, it SHALL pulse err for one cycle and return to LOAD_A with all counters cleared.
REQ-021 add_done SHALL be ignored in every state except WAIT.
REQ-022 In DRAIN, m_valid SHALL be 1 and m_data SHALL be result word k, LSW first; the final word SHALL be zero-extended above bit OP_WIDTH.
REQ-023 m_data SHALL advance only on m_valid&&m_ready and hold while m_ready=0; m_last SHALL be 1 on word NWORDS-1.
REQ-024 Acceptance of the last output word SHALL return the FSM to LOAD_A in the next cycle; back-to-back operations SHALL need no idle cycles.
REQ-025 A single word counter (width clog2(NWORDS)) SHALL be shared by load and drain and cleared on each state change.

Reset
REQ-026 Reset SHALL force state LOAD_A, counter 0 and timeout count 0.
REQ-027 Reset SHALL clear all outputs: s_ready=1, m_valid=0, m_last=0, add_start=0, add_subtract=0, err=0, busy=0, and add_a, add_b, m_data all 0.
REQ-028 Reset asserted mid-load, mid-WAIT or mid-DRAIN SHALL discard the operation; no add_start and no m_valid may follow reset.

Structure
REQ-029 OP_WIDTH, WORD, NWORDS and the state encoding SHALL live in the shared package mp_pkg.
REQ-030 SHALL contain one sub-module, mp_word_shifter: a WORD-in/WORD-out shift register of NWORDS words, instanced for A, B and the result; the block SHALL NOT instantiate the adder.

Verification
REQ-031 A=1, B=2, s_sub=0, adder model returns A+B -> output words 3, then 0 x32; m_last on word 33.
REQ-032 A=5, B=7, s_sub=1 -> add_subtract=1 during WAIT; output word0=0xFFFFFFFE, words 1-31=0xFFFFFFFF, word32=0x0000000F.
REQ-033 A=B=2^1027-1, add -> output identical to REQ-032; input bits above 1026 of word 32 set to 1 are ignored.
REQ-034 m_ready toggling 1/0 every cycle and s_valid with random gaps -> no lost or duplicated words; m_data stable while m_ready=0.
REQ-035 Reset pulse after 10 words of A, then a full fresh operation A=1, B=2 -> correct result 3, no stale start.
REQ-036 add_done held 0 after FIRE -> err pulses exactly TIMEOUT cycles after FIRE, then s_ready=1 and the next operation completes normally.

Source files
------------

// File: rtl/mp_pkg.sv
// Shared widths and FSM encoding for the multiprecision operand loader.
package mp_pkg;

   localparam int unsigned OP_WIDTH = 1027;
   localparam int unsigned WORD     = 32;
   localparam int unsigned NWORDS   = (OP_WIDTH + 1 + WORD - 1) / WORD;
   localparam int unsigned TIMEOUT  = 16;

   typedef enum logic [2:0] {
      ST_LOAD_A,
      ST_LOAD_B,
      ST_FIRE,
      ST_WAIT,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/mp_word_shifter.sv
// NWORDS-deep word shift register: words enter at the top so the first word
// ends up least significant; optional parallel load for draining results.
module mp_word_shifter #(
   parameter int unsigned WORD   = 32,
   parameter int unsigned NWORDS = 33,
   parameter int unsigned OUT_W  = WORD * NWORDS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic [WORD*NWORDS-1:0]   load_data,
   input  logic                     shift,
   input  logic [WORD-1:0]          din,
   output logic [OUT_W-1:0]         data
);

   logic [WORD*NWORDS-1:0] sr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr <= '0;
      end else if (load) begin
         sr <= load_data;
      end else if (shift) begin
         sr <= {din, sr[WORD*NWORDS-1:WORD]};
      end
   end

   assign data = sr[OUT_W-1:0];

endmodule

// File: rtl/mp_operand_loader.sv
// Streams two operands in word by word, fires an external multiprecision
// adder, waits (with timeout) for its result and streams the result back out.
module mp_operand_loader #(
   parameter int unsigned OP_WIDTH = mp_pkg::OP_WIDTH,
   parameter int unsigned WORD     = mp_pkg::WORD,
   parameter int unsigned NWORDS   = mp_pkg::NWORDS,
   parameter int unsigned TIMEOUT  = mp_pkg::TIMEOUT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WORD-1:0]     s_data,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic                s_sub,
   output logic [WORD-1:0]     m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                m_last,
   output logic [OP_WIDTH-1:0] add_a,
   output logic [OP_WIDTH-1:0] add_b,
   output logic                add_subtract,
   output logic                add_start,
   input  logic [OP_WIDTH:0]   add_result,
   input  logic                add_done,
   output logic                busy,
   output logic                err
);

   import mp_pkg::*;

   localparam int unsigned CW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int unsigned TW  = $clog2(TIMEOUT + 1);
   localparam int unsigned SRW = WORD * NWORDS;
   localparam logic [CW-1:0] CNT_LAST = CW'(NWORDS - 1);
   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

   state_t            state, state_n;
   logic [CW-1:0]     cnt;
   logic [TW-1:0]     tcnt;
   logic              sub_r;
   logic              cnt_last;
   logic              t_expired;
   logic              capture;
   logic [SRW-1:0]    res_ext;

   assign cnt_last  = (cnt == CNT_LAST);
   assign t_expired = (tcnt == T_LAST);
   assign capture   = (state == ST_WAIT) && add_done;
   assign busy      = (state != ST_LOAD_A) || (cnt != '0);
   assign add_subtract = sub_r;

   always_comb begin
      state_n   = state;
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      m_last    = 1'b0;
      add_start = 1'b0;
      err       = 1'b0;
      case (state)
         ST_LOAD_A: begin
            s_ready = 1'b1;
            if (s_valid && cnt_last) state_n = ST_LOAD_B;
         end
         ST_LOAD_B: begin
            s_ready = 1'b1;
            if (s_valid && cnt_last) state_n = ST_FIRE;
         end
         ST_FIRE: begin
            add_start = 1'b1;
            state_n   = ST_WAIT;
         end
         ST_WAIT: begin
            if (add_done) begin
               state_n = ST_DRAIN;
            end else if (t_expired) begin
               err     = 1'b1;
               state_n = ST_LOAD_A;
            end
         end
         ST_DRAIN: begin
            m_valid = 1'b1;
            m_last  = cnt_last;
            if (m_ready && cnt_last) state_n = ST_LOAD_A;
         end
         default: state_n = ST_LOAD_A;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_LOAD_A;
         cnt   <= '0;
         tcnt  <= '0;
         sub_r <= 1'b0;
      end else begin
         state <= state_n;
         // One counter serves load and drain; any state change restarts it.
         if (state_n != state) begin
            cnt <= '0;
         end else if ((s_valid && s_ready) || (m_valid && m_ready)) begin
            cnt <= cnt + CW'(1);
         end
         if ((state == ST_WAIT) && (state_n == ST_WAIT)) begin
            tcnt <= tcnt + TW'(1);
         end else begin
            tcnt <= '0;
         end
         if ((state == ST_LOAD_A) && s_valid && (cnt == '0)) begin
            sub_r <= s_sub;
         end
      end
   end

   always_comb begin
      res_ext               = '0;
      res_ext[OP_WIDTH:0]   = add_result;
   end

   mp_word_shifter #(
      .WORD   (WORD),
      .NWORDS (NWORDS),
      .OUT_W  (OP_WIDTH)
   ) u_shift_a (
      .clk       (clk),
      .reset     (reset),
      .load      (1'b0),
      .load_data ('0),
      .shift     ((state == ST_LOAD_A) && s_valid),
      .din       (s_data),
      .data      (add_a)
   );

   mp_word_shifter #(
      .WORD   (WORD),
      .NWORDS (NWORDS),
      .OUT_W  (OP_WIDTH)
   ) u_shift_b (
      .clk       (clk),
      .reset     (reset),
      .load      (1'b0),
      .load_data ('0),
      .shift     ((state == ST_LOAD_B) && s_valid),
      .din       (s_data),
      .data      (add_b)
   );

   mp_word_shifter #(
      .WORD   (WORD),
      .NWORDS (NWORDS),
      .OUT_W  (WORD)
   ) u_shift_res (
      .clk       (clk),
      .reset     (reset),
      .load      (capture),
      .load_data (res_ext),
      .shift     (m_valid && m_ready),
      .din       ('0),
      .data      (m_data)
   );

endmodule
